alu_seq: RTL and testbench

- Sequential, parametrised successor to the processor's combinational 4-bit ALU. Operand width is generalised to W.
- The ALU keeps its own registered carry flag, which enables add-with-carry and rotate-through-carry.
- Adds an iterative shift-add multiply that takes several cycles.
- Sits between the accumulator/data bus and the decode unit. Decode issues an operation with `start`, and the ALU reports completion with `done`.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq issue/result bundle between decode and the ALU.
// Decode drives the master side; the ALU is the slave.
interface alu_seq_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   F;
  logic         ready;
  logic         done;
  logic [W-1:0] S;
  logic         C;
  logic         Z;

  modport master (
    output start, A, B, F,
    input  ready, done, S, C, Z
  );

  modport slave (
    input  start, A, B, F,
    output ready, done, S, C, Z
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential W-bit ALU with registered carry/zero flags and
// an optional iterative shift-add multiplier on F=111.
module alu_seq #(
  parameter int W      = 4,
  parameter int MUL_EN = 1
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  localparam bit HAS_MUL = (MUL_EN != 0);
  localparam int CW      = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q;
  logic           ready_q;
  logic           done_q;
  logic [W-1:0]   s_q;
  logic           c_q;
  logic           z_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] prod_q;

  logic [W:0]     res_d;
  logic           is_mul;

  // Single-cycle result, computed one bit wider to expose carry/borrow.
  always_comb begin
    res_d = '0;
    unique case (bus.F)
      3'b000: res_d = {1'b0, bus.A};
      3'b001: res_d = {1'b0, bus.A} - {1'b0, bus.B};
      3'b010: res_d = {1'b0, bus.B};
      3'b011: res_d = {1'b0, bus.A} + {1'b0, bus.B};
      3'b100: res_d = {1'b0, ~(bus.A & bus.B)};
      3'b101: res_d = {1'b0, bus.A} + {1'b0, bus.B}
                      + (W+1)'(c_q);
      3'b110: res_d = {bus.A[W-1], bus.A[W-2:0], c_q};
      3'b111: res_d = {1'b1, {W{1'b0}}};
      default: res_d = '0;
    endcase
  end

  assign is_mul = HAS_MUL && (bus.F == 3'b111);

  // Control FSM, multiplier datapath and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      s_q      <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_mul) begin
              mcand_q  <= {{W{1'b0}}, bus.A};
              mplier_q <= bus.B;
              prod_q   <= '0;
              cnt_q    <= '0;
              ready_q  <= 1'b0;
              state_q  <= MUL;
            end else begin
              s_q    <= res_d[W-1:0];
              c_q    <= res_d[W];
              z_q    <= (res_d[W-1:0] == '0);
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          s_q     <= prod_q[W-1:0];
          c_q     <= |prod_q[2*W-1:W];
          z_q     <= (prod_q[W-1:0] == '0);
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.S     = s_q;
  assign bus.C     = c_q;
  assign bus.Z     = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq, W=4, with a MUL_EN=1 and a
// MUL_EN=0 instance driven by the same stimulus.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   f = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus0 ();
  alu_seq_if #(.W(W)) bus1 ();

  assign bus0.start = start;
  assign bus0.A     = a;
  assign bus0.B     = b;
  assign bus0.F     = f;
  assign bus1.start = start;
  assign bus1.A     = a;
  assign bus1.B     = b;
  assign bus1.F     = f;

  alu_seq #(.W(W), .MUL_EN(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  alu_seq #(.W(W), .MUL_EN(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] xf,
                       input logic [W-1:0] xa,
                       input logic [W-1:0] xb);
    f = xf;
    a = xa;
    b = xb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows a multiply already issued; optionally pokes start mid-run.
  task automatic mul_wait(input bit pulse,
                          input logic [W-1:0] s0,
                          output int lat,
                          output int nlow,
                          output int ndone,
                          output logic [W-1:0] rs,
                          output logic rc,
                          output logic rz,
                          output logic held);
    lat   = 0;
    nlow  = bus0.ready ? 0 : 1;
    ndone = bus0.done ? 1 : 0;
    held  = (bus0.S === s0);
    rs    = '0;
    rc    = 1'b0;
    rz    = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (pulse && i == 2) begin
        start = 1'b1;
        f = 3'b000;
        a = '0;
        b = '0;
      end
      tick();
      start = 1'b0;
      if (!bus0.ready) nlow++;
      if (bus0.done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          rs  = bus0.S;
          rc  = bus0.C;
          rz  = bus0.Z;
        end
      end else if (lat == 0 && bus0.S !== s0) begin
        held = 1'b0;
      end
    end
  endtask

  initial begin
    int lat, nlow, ndone, nd;
    logic [W-1:0] rs, s0;
    logic rc, rz, held;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_S", 8'(bus0.S), 8'h0);
    chk("rst_C", 8'(bus0.C), 8'h0);
    chk("rst_Z", 8'(bus0.Z), 8'h1);
    chk("rst_rdy", 8'(bus0.ready), 8'h1);
    chk("rst_done", 8'(bus0.done), 8'h0);

    issue(3'b011, 4'h9, 4'h8);
    chk("add_S", 8'(bus0.S), 8'h1);
    chk("add_C", 8'(bus0.C), 8'h1);
    chk("add_Z", 8'(bus0.Z), 8'h0);
    chk("add_done", 8'(bus0.done), 8'h1);
    chk("add_rdy", 8'(bus0.ready), 8'h1);
    issue(3'b101, 4'h2, 4'h3);
    chk("adc_S", 8'(bus0.S), 8'h6);
    chk("adc_C", 8'(bus0.C), 8'h0);
    chk("adc_done", 8'(bus0.done), 8'h1);
    tick();
    chk("idle_done", 8'(bus0.done), 8'h0);
    chk("idle_hold", 8'(bus0.S), 8'h6);

    issue(3'b001, 4'h5, 4'h5);
    chk("cmp_eq_S", 8'(bus0.S), 8'h0);
    chk("cmp_eq_C", 8'(bus0.C), 8'h0);
    chk("cmp_eq_Z", 8'(bus0.Z), 8'h1);
    issue(3'b001, 4'h3, 4'h5);
    chk("cmp_lt_S", 8'(bus0.S), 8'he);
    chk("cmp_lt_C", 8'(bus0.C), 8'h1);
    chk("cmp_lt_Z", 8'(bus0.Z), 8'h0);

    issue(3'b100, 4'hf, 4'hf);
    chk("nand_S", 8'(bus0.S), 8'h0);
    chk("nand_C", 8'(bus0.C), 8'h0);
    chk("nand_Z", 8'(bus0.Z), 8'h1);
    issue(3'b010, 4'ha, 4'h7);
    chk("passb_S", 8'(bus0.S), 8'h7);
    issue(3'b000, 4'hc, 4'h7);
    chk("passa_S", 8'(bus0.S), 8'hc);
    issue(3'b011, 4'h9, 4'h8);
    issue(3'b110, 4'h9, 4'h0);
    chk("rot_S", 8'(bus0.S), 8'h3);
    chk("rot_C", 8'(bus0.C), 8'h1);

    s0 = bus0.S;
    issue(3'b111, 4'h7, 4'h3);
    chk("err_S", 8'(bus1.S), 8'h0);
    chk("err_C", 8'(bus1.C), 8'h1);
    chk("err_Z", 8'(bus1.Z), 8'h1);
    chk("err_done", 8'(bus1.done), 8'h1);
    mul_wait(1'b1, s0, lat, nlow, ndone, rs, rc, rz, held);
    chk("mul_lat", 8'(lat), 8'd5);
    chk("mul_nlow", 8'(nlow), 8'd5);
    chk("mul_ndone", 8'(ndone), 8'd1);
    chk("mul_held", 8'(held), 8'h1);
    chk("mul_S", 8'(rs), 8'h5);
    chk("mul_C", 8'(rc), 8'h1);
    chk("mul_Z", 8'(rz), 8'h0);
    chk("mul_rdy", 8'(bus0.ready), 8'h1);

    s0 = bus0.S;
    issue(3'b111, 4'hf, 4'h1);
    chk("err2_S", 8'(bus1.S), 8'h0);
    chk("err2_C", 8'(bus1.C), 8'h1);
    chk("err2_Z", 8'(bus1.Z), 8'h1);
    chk("err2_rdy", 8'(bus1.ready), 8'h1);
    mul_wait(1'b0, s0, lat, nlow, ndone, rs, rc, rz, held);
    chk("mulf_lat", 8'(lat), 8'd5);
    chk("mulf_S", 8'(rs), 8'hf);
    chk("mulf_C", 8'(rc), 8'h0);
    chk("mulf_Z", 8'(rz), 8'h0);

    issue(3'b111, 4'h7, 4'h3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_S", 8'(bus0.S), 8'h0);
    chk("mrst_C", 8'(bus0.C), 8'h0);
    chk("mrst_Z", 8'(bus0.Z), 8'h1);
    chk("mrst_rdy", 8'(bus0.ready), 8'h1);
    chk("mrst_done", 8'(bus0.done), 8'h0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.done) nd++;
    end
    chk("mrst_nodone", 8'(nd), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
